// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_pkg;

    localparam int unsigned R0_IDX = 0;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // True when addr names a real, writable register (used by write and bypass paths).
    function automatic logic writable(input int unsigned addr, input int unsigned depth,
                                      input logic r0_zero);
        return (addr < depth) && !(r0_zero && (addr == R0_IDX));
    endfunction

endpackage

// File: rtl/register_n.sv
// Clear/enable register with asynchronous active-low reset; Clear has priority over Write.
module register_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Clear,
    input  logic             Write,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (Clear) begin
            q_d = '0;
        end else if (Write) begin
            q_d = D;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/register_file_n.sv
// N-entry register file: one synchronous write port, two combinational read ports with
// optional write bypass, optional hard-wired-zero R0 and a per-register valid scoreboard.
module register_file_n
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter bit          R0_ZERO = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = addr_width(DEPTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Clear,
    input  logic             Write,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddrA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] RdDataA,
    output logic [WIDTH-1:0] RdDataB,
    input  logic             Invalidate,
    input  logic [AW-1:0]    InvAddr,
    output logic             ValidA,
    output logic             ValidB
);

    logic [WIDTH-1:0] q_arr [DEPTH];
    logic [DEPTH-1:0] wr_mask;
    logic [DEPTH-1:0] inv_mask;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Per-register decode; a zero R0 has no storage and cannot be written or invalidated.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (R0_ZERO && (i == 0)) begin : g_zero
            assign wr_mask[i]  = 1'b0;
            assign inv_mask[i] = 1'b0;
            assign q_arr[i]    = '0;
        end else begin : g_store
            assign wr_mask[i]  = Write && (WrAddr == AW'(i));
            assign inv_mask[i] = Invalidate && (InvAddr == AW'(i));
            register_n #(.WIDTH(WIDTH)) u_reg (
                .Clock  (Clock),
                .Resetn (Resetn),
                .Clear  (Clear),
                .Write  (wr_mask[i]),
                .D      (WrData),
                .Q      (q_arr[i])
            );
        end
    end

    // Write sets valid after invalidate clears it, so a same-address write wins.
    always_comb begin
        valid_d = (valid_q & ~inv_mask) | wr_mask;
        if (Clear) begin
            valid_d = '1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            valid_q <= '1;
        end else begin
            valid_q <= valid_d;
        end
    end

    logic wr_fwd_ok;
    logic hit_a;
    logic hit_b;
    logic in_a;
    logic in_b;

    assign wr_fwd_ok = BYPASS && Resetn && Write && !Clear
                       && writable(32'(WrAddr), DEPTH, R0_ZERO);
    assign hit_a = wr_fwd_ok && (RdAddrA == WrAddr);
    assign hit_b = wr_fwd_ok && (RdAddrB == WrAddr);
    assign in_a  = 32'(RdAddrA) < DEPTH;
    assign in_b  = 32'(RdAddrB) < DEPTH;

    // Read muxes: bypass first, then stored value; unmapped addresses read 0 / valid.
    always_comb begin
        RdDataA = '0;
        ValidA  = 1'b1;
        if (hit_a) begin
            RdDataA = WrData;
        end else if (in_a) begin
            RdDataA = q_arr[RdAddrA];
            ValidA  = valid_q[RdAddrA];
        end
    end

    always_comb begin
        RdDataB = '0;
        ValidB  = 1'b1;
        if (hit_b) begin
            RdDataB = WrData;
        end else if (in_b) begin
            RdDataB = q_arr[RdAddrB];
            ValidB  = valid_q[RdAddrB];
        end
    end

endmodule
